// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type, init-mode codes and clog2 helper for regfile_param
package regfile_pkg;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/regfile_init_fsm.sv
// regfile_init_fsm: sequential init engine owning state, init pointer, busy and write-drop flag
module regfile_init_fsm
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int INIT_MODE = 1,
    localparam int ADDR_W   = clog2(DEPTH)
)(
    input  logic              clock_in,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              init_req,
    output logic              busy,
    output logic              wr_drop,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_val
);
    state_t            state, state_n;
    logic [ADDR_W-1:0] init_ptr, ptr_n;
    logic              last;

    // next state: walk every entry while in INIT, restart from entry 0 on init_req in RUN
    always_comb begin
        last    = init_ptr == ADDR_W'(DEPTH - 1);
        state_n = state == ST_INIT ? (last ? ST_RUN : ST_INIT) : (init_req ? ST_INIT : ST_RUN);
        ptr_n   = state == ST_INIT && !last ? init_ptr + 1'b1 : '0;
    end

    // control registers; a write is dropped when the engine owns the array or a reload is starting
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_ptr <= '0;
            busy     <= 1'b1;
            wr_drop  <= 1'b0;
        end else begin
            state    <= state_n;
            init_ptr <= ptr_n;
            busy     <= state_n == ST_INIT;
            wr_drop  <= wr_en && (busy || init_req);
        end
    end

    assign init_we   = state == ST_INIT;
    assign init_addr = init_ptr;
    assign init_val  = INIT_MODE == INIT_INDEX ? DATA_W'(init_ptr) : '0;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with init engine; REGFILE_BYPASS_EN adds same-cycle write-to-read bypass
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int NUM_RD    = 2,
    parameter int INIT_MODE = 1,
    parameter int ZERO_REG  = 1,
    localparam int ADDR_W   = clog2(DEPTH)
)(
    input  logic                     clock_in,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     init_req,
    output logic                     busy,
    output logic                     wr_drop,
    input  logic [ADDR_W-1:0]        dbg_sel,
    output logic [7:0]               dbg_data
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_val;
    logic              wr_ok;

    regfile_init_fsm #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .INIT_MODE(INIT_MODE)
    ) u_fsm (
        .clock_in (clock_in),
        .reset    (reset),
        .wr_en    (wr_en),
        .init_req (init_req),
        .busy     (busy),
        .wr_drop  (wr_drop),
        .init_we  (init_we),
        .init_addr(init_addr),
        .init_val (init_val)
    );

    assign wr_ok = wr_en && !busy && !init_req && !(ZERO_REG != 0 && wr_addr == '0);

    // array write: the init engine has priority; user writes land only in RUN
    always_ff @(posedge clock_in) begin
        if (init_we)
            mem[init_addr] <= init_val;
        else if (wr_ok)
            mem[wr_addr] <= wr_data;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit;
        assign a = rd_addr[p*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign hit = wr_en && !busy && wr_addr == a;
`else
        assign hit = 1'b0;
`endif
        assign rd_data[p*DATA_W +: DATA_W] = busy || (ZERO_REG != 0 && a == '0) ? '0 : hit ? wr_data : mem[a];
    end

    assign dbg_data = busy ? '0 : 8'(mem[dbg_sel]);
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file, the next generation of the CPU register file in the ID stage. It has configurable width, depth and read-port count, and an optional hardwired zero register. A sequential init engine loads reset values one entry per cycle, and a re-init request reloads them at runtime. An optional same-cycle write-to-read bypass is available, and writes are synchronous on the rising edge.

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 16, number of entries; power of two, ≥ 2
- NUM_RD, 2, number of independent read ports (1–4)
- INIT_MODE, 1, init value per entry: 0 = all zero, 1 = entry index, zero-extended to DATA_W
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
- ADDR_W, derived = clog2(DEPTH)

Ports:
- clock_in  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port p uses slice p
- rd_data  out  NUM_RD*DATA_W  combinational read data, port p in slice p
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- init_req  in  1  single-cycle request to reload all entries with init values
- busy  out  1  registered; high while the init engine owns the array
- wr_drop  out  1  registered; one-cycle pulse when a write was discarded
- dbg_sel  in  ADDR_W  debug tap select
- dbg_data  out  8  combinational; bits [7:0] of entry dbg_sel, 0 while busy

## Operation
- FSM states:
  - INIT: the engine writes the init value to entry init_ptr each cycle.
  - RUN: normal operation.
- Reset asserted: state = INIT, init_ptr = 0, busy = 1, wr_drop = 0. The array itself is not reset.
- INIT, each rising edge:
  - Write the init value for init_ptr into entry init_ptr, then increment init_ptr.
  - When init_ptr = DEPTH-1, go to RUN; busy falls on the same edge.
- RUN, init_req = 1: go to INIT with init_ptr = 0 and busy = 1 on the next edge.
  - A write in that same cycle is discarded and wr_drop = 1 next cycle.
- A write while busy is discarded, and wr_drop = 1 next cycle.
- With ZERO_REG = 1, writes to address 0 are silently discarded; wr_drop is not raised.
- init_req while already in INIT is ignored; the pass in progress continues.
- Reads:
  - rd_data[p] = entry[rd_addr[p]].
  - It is forced to 0 when busy = 1, or when ZERO_REG = 1 and rd_addr[p] = 0.
- Ports are fully independent; any number may read the same address.

## Timing
- Read latency 0 (combinational from rd_addr).
- Write latency: visible on rd_data after the rising edge that captures wr_en.
- Init duration: DEPTH cycles after reset deasserts or after the init_req edge. busy is low from cycle DEPTH onward.
- wr_drop: exactly 1 cycle wide, aligned to the edge after the discarded write.
- Reset mid-init: restarts from init_ptr = 0.
- Reset mid-write: the write is lost and the array contents are undefined until init completes.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When wr_en = 1, busy = 0 and wr_addr = rd_addr[p] (non-zero address when ZERO_REG = 1), rd_data[p] returns wr_data in the same cycle.
  - Required for the pipeline's WB→ID same-cycle forwarding.
- Undefined: rd_data[p] returns the old contents until the next edge.
- The zero-register and busy forcing take priority over the bypass in both builds.

## Structure
- Package regfile_pkg:
  - FSM state enum (ST_INIT, ST_RUN)
  - INIT_MODE constants (INIT_ZERO = 0, INIT_INDEX = 1)
  - clog2 helper function
- Sub-module regfile_init_fsm: owns state, init_ptr, busy and wr_drop, and outputs the init write enable, address and value. The top level holds the array, write mux, read muxes and bypass.

## Test plan
- Reset, then deassert; sample busy over 16 cycles (defaults) -> busy = 1 for cycles 0–15, 0 from cycle 16. Afterwards entry k reads k on both ports for k = 0..15.
- RUN: write 0xDEADBEEF to addr 5, then read ports 0 and 1 at 5 -> 0xDEADBEEF the cycle after the write. With REGFILE_BYPASS_EN, it also appears in the write cycle.
- Write 0x1234 to addr 0 with ZERO_REG = 1 -> addr 0 still reads 0 and wr_drop stays 0.
- Write addr 3 while busy, and write addr 7 in the same cycle as init_req -> wr_drop pulses once for each. After init, entry 3 = 3 and entry 7 = 7.
- Write 0xAA to addr 9 and set dbg_sel = 9 -> dbg_data = 0xAA. Then pulse init_req -> dbg_data = 0 while busy, and 0x09 after 16 cycles.
- Assert reset at init_ptr = 8 for 1 cycle -> busy stays 1, and init completes 16 cycles after release, not 8.
